// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, error codes, RAM port levels and FSM encoding for the MEM-stage
// load/store unit.
package mem_access_unit_pkg;

   localparam logic [3:0] MEM_OP_LB  = 4'd0;
   localparam logic [3:0] MEM_OP_LBU = 4'd1;
   localparam logic [3:0] MEM_OP_LH  = 4'd2;
   localparam logic [3:0] MEM_OP_LHU = 4'd3;
   localparam logic [3:0] MEM_OP_LW  = 4'd4;
   localparam logic [3:0] MEM_OP_SB  = 4'd5;
   localparam logic [3:0] MEM_OP_SH  = 4'd6;
   localparam logic [3:0] MEM_OP_SW  = 4'd7;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic is_store(input logic [3:0] op);
      return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword lane of a big-endian RAM word and
// sign- or zero-extends it according to the load op.
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   function automatic logic [31:0] sext8(input logic signed [7:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   always_comb begin
      case (addr_lo)
         2'd0:    byte_lane = raw[31:24];
         2'd1:    byte_lane = raw[23:16];
         2'd2:    byte_lane = raw[15:8];
         default: byte_lane = raw[7:0];
      endcase
      half_lane = addr_lo[1] ? raw[15:0] : raw[31:16];

      case (op)
         MEM_OP_LB:  result = sext8(byte_lane);
         MEM_OP_LBU: result = {24'd0, byte_lane};
         MEM_OP_LH:  result = sext16(half_lane);
         MEM_OP_LHU: result = {16'd0, half_lane};
         default:    result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: one request at a time, drives the data RAM for a
// single ACCESS cycle and returns a registered, lane-aligned result or error code.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_ADDR_LOG2 = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [1:0]  resp_err,
   output logic        ram_en,
   output logic        ram_write_en,
   output logic [3:0]  ram_write_sel,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_write_data,
   input  logic [31:0] ram_read_data
);

   state_t      state, state_nxt;
   logic [3:0]  op_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;
   logic [31:0] data_p1;
   logic [1:0]  err_p1;

   logic        accept;
   logic        misaligned;
   logic        out_of_range;
   logic [31:0] load_val;

   load_align u_load_align (
      .op      (op_p0),
      .addr_lo (addr_p0[1:0]),
      .raw     (ram_read_data),
      .result  (load_val)
   );

   // Request classification; misaligned wins over out of range
   always_comb begin
      case (req_op)
         MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB:  misaligned = 1'b0;
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  misaligned = req_addr[0];
         default:                           misaligned = |req_addr[1:0];
      endcase
      out_of_range = |(req_addr >> MEM_ADDR_LOG2);
   end

   assign accept = req_valid && req_ready;

   always_comb begin
      state_nxt      = state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_data      = 32'd0;
      resp_err       = ERR_OK;
      ram_en         = CHIP_DISABLE;
      ram_write_en   = WRITE_DISABLE;
      ram_write_sel  = 4'b0000;
      ram_addr       = 32'd0;
      ram_write_data = 32'd0;

      case (state)
         ST_IDLE: begin
            req_ready = !flush;
            if (req_valid && !flush)
               state_nxt = (misaligned || out_of_range) ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            state_nxt = ST_RESP;
            if (!flush) begin
               ram_en   = CHIP_ENABLE;
               ram_addr = addr_p0;
               case (op_p0)
                  MEM_OP_SB: begin
                     ram_write_en   = WRITE_ENABLE;
                     ram_write_sel  = 4'b1000 >> addr_p0[1:0];
                     ram_write_data = {4{wdata_p0[7:0]}};
                  end
                  MEM_OP_SH: begin
                     ram_write_en   = WRITE_ENABLE;
                     ram_write_sel  = addr_p0[1] ? 4'b0011 : 4'b1100;
                     ram_write_data = {2{wdata_p0[15:0]}};
                  end
                  MEM_OP_SW: begin
                     ram_write_en   = WRITE_ENABLE;
                     ram_write_sel  = 4'b1111;
                     ram_write_data = wdata_p0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RESP: begin
            resp_valid = !flush;
            resp_data  = data_p1;
            resp_err   = err_p1;
            if (resp_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (flush)
         state_nxt = ST_IDLE;

      // Reset silences every output in the same cycle so an in-flight store cannot commit
      if (!rst) begin
         state_nxt      = ST_IDLE;
         req_ready      = 1'b0;
         resp_valid     = 1'b0;
         resp_data      = 32'd0;
         resp_err       = ERR_OK;
         ram_en         = CHIP_DISABLE;
         ram_write_en   = WRITE_DISABLE;
         ram_write_sel  = 4'b0000;
         ram_addr       = 32'd0;
         ram_write_data = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         op_p0    <= 4'd0;
         addr_p0  <= 32'd0;
         wdata_p0 <= 32'd0;
         data_p1  <= 32'd0;
         err_p1   <= ERR_OK;
      end else begin
         state <= state_nxt;
         // Stage p0: latch the accepted request and its error classification
         if (accept) begin
            op_p0    <= req_op;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            data_p1  <= 32'd0;
            err_p1   <= misaligned   ? ERR_MISALIGN :
                        out_of_range ? ERR_RANGE    : ERR_OK;
         end
         // Stage p1: register the extended load result at the end of ACCESS
         if (state == ST_ACCESS)
            data_p1 <= is_store(op_p0) ? 32'd0 : load_val;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-write RAM model on the RAM port.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        ram_en;
   logic        ram_write_en;
   logic [3:0]  ram_write_sel;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data;

   logic        preload;
   logic [31:0] mem [0:1023];
   logic        any_out;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.MEM_ADDR_LOG2(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .flush          (flush),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_data      (resp_data),
      .resp_err       (resp_err),
      .ram_en         (ram_en),
      .ram_write_en   (ram_write_en),
      .ram_write_sel  (ram_write_sel),
      .ram_addr       (ram_addr),
      .ram_write_data (ram_write_data),
      .ram_read_data  (ram_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_read_data = mem[ram_addr[11:2]];
   assign any_out = |{req_ready, resp_valid, resp_data, resp_err, ram_en, ram_write_en,
                      ram_write_sel, ram_addr, ram_write_data};

   always @(posedge clk) begin
      if (preload) begin
         mem[4]  <= 32'h8899AABB;
         mem[8]  <= 32'h11223344;
         mem[9]  <= 32'h55556666;
         mem[10] <= 32'h00000000;
      end else if (ram_en && ram_write_en) begin
         if (ram_write_sel[3]) mem[ram_addr[11:2]][31:24] <= ram_write_data[31:24];
         if (ram_write_sel[2]) mem[ram_addr[11:2]][23:16] <= ram_write_data[23:16];
         if (ram_write_sel[1]) mem[ram_addr[11:2]][15:8]  <= ram_write_data[15:8];
         if (ram_write_sel[0]) mem[ram_addr[11:2]][7:0]   <= ram_write_data[7:0];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request at posedge+1 timing, watch ACCESS, take the response.
   task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic en_seen, output logic we_seen, output logic [3:0] sel,
                          output logic [31:0] wd, output logic [31:0] ra,
                          output logic [31:0] data, output logic [1:0] err, output int lat);
      en_seen = 1'b0; we_seen = 1'b0; sel = 4'd0; wd = 32'd0; ra = 32'd0;
      data = 32'd0; err = 2'd0; lat = 0;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (ram_en) begin
            en_seen = 1'b1; we_seen = ram_write_en; sel = ram_write_sel;
            wd = ram_write_data; ra = ram_addr;
         end
         if (resp_valid) begin
            lat = c; data = resp_data; err = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat != 0) begin
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end
   endtask

   task automatic load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] exp_data, input logic [1:0] exp_err, input int exp_lat);
      logic en, we; logic [3:0] sel; logic [31:0] wd, ra, data; logic [1:0] err; int lat;
      run_req(op, addr, 32'd0, en, we, sel, wd, ra, data, err, lat);
      check({tag, "_data"}, data, exp_data);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (exp_err != ERR_OK) check({tag, "_ram_en"}, 32'(en), 32'd0);
   endtask

   task automatic store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] exp_sel,
                        input logic [31:0] exp_wd);
      logic en, we; logic [3:0] sel; logic [31:0] wd, ra, data; logic [1:0] err; int lat;
      run_req(op, addr, wdata, en, we, sel, wd, ra, data, err, lat);
      check({tag, "_we"}, 32'(we), 32'd1);
      check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
      check({tag, "_wdata"}, wd, exp_wd);
      check({tag, "_addr"}, ra, addr);
      check({tag, "_resp"}, {data[29:0], err}, 32'd0);
      check({tag, "_lat"}, 32'(lat), 32'd2);
   endtask

   initial begin
      logic seen;
      rst = 1'b0; preload = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0;
      req_wdata = 32'd0; flush = 1'b0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      check("reset_outputs_zero", 32'(any_out), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(req_ready), 32'd1);
      @(posedge clk); #1;

      load("lb_11",  MEM_OP_LB,  32'h11, 32'hFFFFFF99, ERR_OK, 2);
      load("lbu_11", MEM_OP_LBU, 32'h11, 32'h00000099, ERR_OK, 2);
      load("lh_12",  MEM_OP_LH,  32'h12, 32'hFFFFAABB, ERR_OK, 2);
      load("lhu_10", MEM_OP_LHU, 32'h10, 32'h00008899, ERR_OK, 2);

      store("sb_13", MEM_OP_SB, 32'h13, 32'h12345677, 4'b0001, 32'h77777777);
      load("lw_after_sb", MEM_OP_LW, 32'h10, 32'h8899AA77, ERR_OK, 2);
      store("sh_12", MEM_OP_SH, 32'h12, 32'h0000CAFE, 4'b0011, 32'hCAFECAFE);
      load("lw_after_sh", MEM_OP_LW, 32'h10, 32'h8899CAFE, ERR_OK, 2);
      store("sw_28", MEM_OP_SW, 32'h28, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      load("lw_28", MEM_OP_LW, 32'h28, 32'hDEADBEEF, ERR_OK, 2);

      load("lw_misalign", MEM_OP_LW, 32'h12,       32'd0, ERR_MISALIGN, 1);
      load("lw_range",    MEM_OP_LW, 32'h00001000, 32'd0, ERR_RANGE,    1);
      load("lh_both",     MEM_OP_LH, 32'h00001001, 32'd0, ERR_MISALIGN, 1);

      // flush during ACCESS of a store
      req_valid = 1'b1; req_op = MEM_OP_SW; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1 req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      check("flush_access_ram", 32'({ram_en, ram_write_en, ram_write_sel}), 32'd0);
      @(posedge clk); #1 flush = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("flush_no_resp", 32'(seen), 32'd0);
      @(posedge clk); #1;
      load("lw_20_old", MEM_OP_LW, 32'h20, 32'h11223344, ERR_OK, 2);

      // flush in IDLE blocks acceptance
      req_valid = 1'b1; req_op = MEM_OP_LW; req_addr = 32'h10; flush = 1'b1;
      @(negedge clk);
      check("flush_idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_idle_no_access", 32'({ram_en, resp_valid}), 32'd0);
      @(posedge clk); #1;

      // backpressure: response held for 5 cycles
      req_valid = 1'b1; req_op = MEM_OP_LW; req_addr = 32'h10;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_data", resp_data, 32'h8899CAFE);
         check("hold_ready_low", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
      @(negedge clk);
      check("hold_release", 32'({resp_valid, req_ready}), 32'b01);
      @(posedge clk); #1;

      // reset during ACCESS of a store
      req_valid = 1'b1; req_op = MEM_OP_SW; req_addr = 32'h24; req_wdata = 32'hA5A5A5A5;
      @(posedge clk); #1 req_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("rst_access_ram", 32'({ram_en, ram_write_en, ram_write_sel}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_access_outputs", 32'(any_out), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rst_access_release", 32'({resp_valid, req_ready}), 32'b01);
      @(posedge clk); #1;
      load("lw_24_old", MEM_OP_LW, 32'h24, 32'h55556666, ERR_OK, 2);

      // reset during RESP of a load
      req_valid = 1'b1; req_op = MEM_OP_LB; req_addr = 32'h11;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_resp_pre", 32'(resp_valid), 32'd1);
      rst = 1'b0;
      #1 check("rst_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_resp_outputs", 32'(any_out), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rst_resp_release", 32'({resp_valid, req_ready}), 32'b01);
      @(posedge clk); #1;
      load("lbu_after_rst", MEM_OP_LBU, 32'h11, 32'h00000099, ERR_OK, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end for the CPU's MEM stage; sits directly upstream of the data RAM.
- Accepts one memory request at a time from the pipeline over a valid/ready handshake.
- Drives the RAM's enable, write-enable, byte-select, address and write-data ports, and captures the RAM's combinational read data.
- Returns a registered, lane-aligned, sign/zero-extended load result or an error code.
- Byte order is big-endian: byte offset 0 is bits [31:24] and write_sel[3].

Parameters:
MEM_ADDR_LOG2, 12, log2 of RAM size in bytes; any address with a set bit at or above this position is out of range.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  4  memory op code: LB, LBU, LH, LHU, LW, SB, SH, SW
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
flush  in  1  cancel any in-flight request
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_data  out  32  load result; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned, 10 out of range
ram_en  out  1  to RAM ram_en
ram_write_en  out  1  to RAM write_en
ram_write_sel  out  4  to RAM write_sel
ram_addr  out  32  to RAM addr
ram_write_data  out  32  to RAM write_data
ram_read_data  in  32  from RAM read_data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset drives state to IDLE, clears all request/response registers, and holds every output at 0.
- req_ready = (state==IDLE) && !flush.
- IDLE: on req_valid && req_ready, latch op, addr and wdata, then classify the request:
  - Misaligned: halfword with addr[0]!=0, or word with addr[1:0]!=0. Go to RESP with err=01.
  - Out of range: any of addr[31:MEM_ADDR_LOG2] nonzero. Go to RESP with err=10. Misaligned takes priority over out of range.
  - Otherwise go to ACCESS.
- ACCESS lasts exactly one cycle:
  - ram_en=1; ram_addr = latched address.
  - Stores: ram_write_en=1.
    - SB: ram_write_sel=4'b1000>>addr[1:0]; ram_write_data={4{wdata[7:0]}}.
    - SH: ram_write_sel = 4'b1100 (addr[1]=0) or 4'b0011 (addr[1]=1); ram_write_data={2{wdata[15:0]}}.
    - SW: ram_write_sel=4'b1111; ram_write_data=wdata.
    - The RAM commits the write on the clk edge ending ACCESS.
  - Loads: ram_write_en=0, ram_write_sel=0. ram_read_data is lane-extracted and extended, then registered into resp_data on the edge ending ACCESS.
  - Then go to RESP.
- RAM port outputs are zero in every state other than ACCESS. Errored requests never assert ram_en.
- RESP: resp_valid=1. resp_data and resp_err stay stable until resp_ready. On resp_ready, go to IDLE.
- Latency: request accepted at edge T, ACCESS in cycle T+1, resp_valid visible from cycle T+2. Throughput is at most 1 request per 3 cycles.
- flush has priority over every other transition:
  - Next state is IDLE and the response is dropped.
  - In ACCESS, flush combinationally forces ram_en, ram_write_en and ram_write_sel to 0 in the same cycle, so no store commits.
  - In RESP, flush forces resp_valid to 0.
  - In IDLE, flush blocks acceptance.
- Reset mid-operation: the request is abandoned, no write commits in the reset cycle (RAM outputs forced 0), and there is no response.
- Load extension:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the selected halfword. LHU: zero-extend it.
  - LW: pass the full word.
- Undefined op codes: treated as LW with no alignment check relaxed. Tests must not depend on this.

Decomposition:
- Shared define file (global_def.v): 4-bit op code constants (MEM_OP_LB…MEM_OP_SW), error code constants, state encodings.
- Reuse the existing CHIP/WRITE enable macros for the RAM port levels.
- One combinational sub-module, load_align: inputs op, addr[1:0], raw word; output the extended result.
- FSM, store lane steering and error checks stay in mem_access_unit.

Test Plan:
- Preload word @0x10 = 0x8899AABB. LB 0x11 -> resp_data 0xFFFFFF99, err 00. LBU 0x11 -> 0x00000099. LH 0x12 -> 0xFFFFAABB. LHU 0x10 -> 0x00008899. resp_valid first seen 2 cycles after acceptance.
- SB addr 0x13, wdata 0x12345677 -> during ACCESS ram_write_sel=0001, ram_write_data=0x77777777. A following LW 0x10 returns 0x8899AA77.
- SH 0x12, wdata 0x0000CAFE -> write_sel 0011, write_data 0xCAFECAFE. LW 0x10 returns 0x8899CAFE.
- LW 0x12 -> err 01, resp_data 0, ram_en never high. LW 0x00001000 with MEM_ADDR_LOG2=12 -> err 10. LH 0x00001001 -> err 01.
- SW 0x20, wdata 0xDEADBEEF with flush asserted during ACCESS -> ram_write_en stays 0, no resp_valid. LW 0x20 returns the old value. Hold resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready low.
- Assert rst=0 in ACCESS of SW and in RESP of LB -> no write, no response; all outputs 0 the next cycle; req_ready=1 after release.
